// File: rtl/test_mem_server_pkg.sv
// Memory request/response message types shared by processor clients and test memories.
// Opaque width is fixed here; instantiating modules must use the same width.
package test_mem_server_pkg;

    localparam int MEM_OPAQ_BITS = 8;

    localparam logic MEM_MSG_READ  = 1'b0;
    localparam logic MEM_MSG_WRITE = 1'b1;

    typedef struct packed {
        logic                     op;
        logic [MEM_OPAQ_BITS-1:0] opaque;
        logic [31:0]              addr;
        logic [1:0]               len;
        logic [31:0]              data;
    } mem_req_t;

    typedef struct packed {
        logic                     op;
        logic [MEM_OPAQ_BITS-1:0] opaque;
        logic [1:0]               len;
        logic [31:0]              data;
    } mem_resp_t;

    // Byte mask of an access with its first byte at lane 0; len 0 means a full word.
    function automatic logic [3:0] mem_len_base(input logic [1:0] len);
        logic [3:0] base;
        case (len)
            2'd0:    base = 4'b1111;
            2'd1:    base = 4'b0001;
            2'd2:    base = 4'b0011;
            default: base = 4'b0111;
        endcase
        return base;
    endfunction

    // Lanes touched at a given byte offset; shifting out of 4 bits truncates at the word end.
    function automatic logic [3:0] mem_byte_mask(input logic [1:0] off, input logic [1:0] len);
        logic [3:0] mask;
        mask = mem_len_base(len) << off;
        return mask;
    endfunction

    function automatic logic [31:0] mem_mask_expand(input logic [3:0] m);
        logic [31:0] bits;
        for (int b = 0; b < 4; b++) begin
            bits[8*b +: 8] = {8{m[b]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/test_mem_server_if.sv
// Memory request/response channel between a processor client (master) and a memory server (slave).
interface test_mem_server_if;
    import test_mem_server_pkg::*;

    logic      req_val;
    logic      req_rdy;
    mem_req_t  req_msg;
    logic      resp_val;
    logic      resp_rdy;
    mem_resp_t resp_msg;

    modport master (output req_val, input req_rdy, output req_msg,
                    input resp_val, output resp_rdy, input resp_msg);
    modport slave  (input req_val, output req_rdy, input req_msg,
                    output resp_val, input resp_rdy, output resp_msg);
endinterface

// File: rtl/test_mem_server_mem_resp_queue.sv
// Circular response FIFO of p_depth entries with valid/ready on both sides.
// Latency: an entry enqueued at an edge is visible at the head the following cycle.
// Backpressure: enq_rdy drops when full; the head and deq_dat hold while deq_rdy is low.
module mem_resp_queue #(
    parameter int p_depth = 4,
    parameter int p_width = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enq_vld,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_dat,
    output logic               deq_vld,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_dat,
    output logic               full,
    output logic               empty
);
    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth + 1);

    logic [p_width-1:0] buf_q [p_depth];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               enq_fire, deq_fire;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (cnt_q == CW'(p_depth));
    assign empty    = (cnt_q == '0);
    assign enq_rdy  = !full;
    assign deq_vld  = !empty;
    assign enq_fire = enq_vld && enq_rdy;
    assign deq_fire = deq_vld && deq_rdy;
    // Empty queue presents zero so the response bus is clean after reset.
    assign deq_dat  = empty ? '0 : buf_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = enq_fire ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq_fire ? ptr_next(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(enq_fire) - CW'(deq_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            buf_q[wr_ptr_q] <= enq_dat;
        end
    end

endmodule

// File: rtl/test_mem_server.sv
// Fixed-latency word-addressed test memory answering read/write requests in order.
// Latency: p_latency cycles from request accept to first resp_val.
// Backpressure: credit count of in-flight plus queued responses gates req_rdy at p_queue_depth.
module test_mem_server
    import test_mem_server_pkg::*;
#(
    parameter int p_opaq_bits   = MEM_OPAQ_BITS,
    parameter int p_num_words   = 256,
    parameter int p_latency     = 2,
    parameter int p_queue_depth = 4
) (
    input  logic              clk,
    input  logic              rst,
    test_mem_server_if.slave  mem,
    input  logic              init_en,
    input  logic [31:0]       init_addr,
    input  logic [31:0]       init_data
);
    localparam int IW   = $clog2(p_num_words);
    localparam int CW   = $clog2(p_queue_depth + 1);
    localparam int NSTG = p_latency - 1;
    localparam int RW   = $bits(mem_resp_t);

    logic [31:0]   mem_q [p_num_words];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_fire, resp_fire;
    logic [IW-1:0] req_idx, init_idx;
    logic [1:0]    req_off;
    logic [3:0]    wr_mask;
    logic [31:0]   wr_shift, rd_word, rd_shift;
    mem_resp_t     resp_new;
    logic          enq_vld, enq_rdy, q_full, q_empty;
    logic [RW-1:0] enq_dat, deq_dat;
    logic          unused_bits;

    assign req_idx     = mem.req_msg.addr[2 +: IW];
    assign req_off     = mem.req_msg.addr[1:0];
    assign init_idx    = init_addr[2 +: IW];
    assign mem.req_rdy = !rst && !init_en && (cnt_q < CW'(p_queue_depth));
    assign req_fire    = mem.req_val && mem.req_rdy;
    assign resp_fire   = mem.resp_val && mem.resp_rdy;

    always_comb begin
        wr_mask  = mem_byte_mask(req_off, mem.req_msg.len);
        wr_shift = mem.req_msg.data << {req_off, 3'b000};
        rd_word  = mem_q[req_idx];
        rd_shift = rd_word >> {req_off, 3'b000};

        resp_new        = '0;
        resp_new.op     = mem.req_msg.op;
        resp_new.opaque = mem.req_msg.opaque[p_opaq_bits-1:0];
        resp_new.len    = mem.req_msg.len;
        if (mem.req_msg.op == MEM_MSG_READ) begin
            resp_new.data = rd_shift & mem_mask_expand(mem_len_base(mem.req_msg.len));
        end
        cnt_d = cnt_q + CW'(req_fire) - CW'(resp_fire);
    end

    // Array is deliberately left out of reset so test images survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem_q[init_idx] <= init_data;
        end else if (req_fire && mem.req_msg.op == MEM_MSG_WRITE) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem_q[req_idx][8*b +: 8] <= wr_shift[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (NSTG == 0) begin : g_nopipe
        assign enq_vld = req_fire;
        assign enq_dat = resp_new;
    end else begin : g_pipe
        logic [NSTG-1:0] stg_vld_q, stg_vld_d;
        mem_resp_t       stg_msg_q [NSTG];
        mem_resp_t       stg_msg_d [NSTG];

        always_comb begin
            stg_vld_d[0] = req_fire;
            stg_msg_d[0] = resp_new;
            for (int i = 1; i < NSTG; i++) begin
                stg_vld_d[i] = stg_vld_q[i-1];
                stg_msg_d[i] = stg_msg_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stg_vld_q <= '0;
            end else begin
                stg_vld_q <= stg_vld_d;
            end
        end

        always_ff @(posedge clk) begin
            stg_msg_q <= stg_msg_d;
        end

        assign enq_vld = stg_vld_q[NSTG-1];
        assign enq_dat = stg_msg_q[NSTG-1];
    end

    // Credits guarantee the queue never overflows, so enq_rdy is always high in practice.
    mem_resp_queue #(
        .p_depth (p_queue_depth),
        .p_width (RW)
    ) u_resp_queue (
        .clk     (clk),
        .rst     (rst),
        .enq_vld (enq_vld),
        .enq_rdy (enq_rdy),
        .enq_dat (enq_dat),
        .deq_vld (mem.resp_val),
        .deq_rdy (mem.resp_rdy),
        .deq_dat (deq_dat),
        .full    (q_full),
        .empty   (q_empty)
    );

    assign mem.resp_msg = deq_dat;

    assign unused_bits = ^{mem.req_msg.addr, init_addr, enq_rdy, q_full, q_empty};

endmodule

// File: tb/tb_test_mem_server.sv
// Directed bench for test_mem_server: vector table for single accesses plus multi-cycle sequences.
module tb_test_mem_server;
    import test_mem_server_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_en;
    logic [31:0] init_addr;
    logic [31:0] init_data;

    test_mem_server_if mem_if ();

    test_mem_server #(
        .p_opaq_bits   (8),
        .p_num_words   (256),
        .p_latency     (2),
        .p_queue_depth (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (mem_if),
        .init_en   (init_en),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic [7:0]  opq;
        logic [31:0] expd;
    } vec_t;

    vec_t      vecs [13];
    mem_resp_t got [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic mem_resp_t exp_resp(input logic op, input logic [7:0] opq,
                                           input logic [1:0] len, input logic [31:0] d);
        mem_resp_t r;
        r.op = op; r.opaque = opq; r.len = len; r.data = d;
        return r;
    endfunction

    task automatic set_req(input logic op, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] data, input logic [7:0] opq);
        mem_req_t m;
        m.op = op; m.opaque = opq; m.addr = addr; m.len = len; m.data = data;
        mem_if.req_val = 1'b1;
        mem_if.req_msg = m;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [31:0] a, input logic [31:0] d);
        init_en = 1'b1; init_addr = a; init_data = d;
        next_cycle();
        init_en = 1'b0;
    endtask

    // One isolated request with resp_rdy high: checks exact p_latency=2 timing and the message.
    task automatic single(input string nm, input logic op, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] data,
                          input logic [7:0] opq, input logic [31:0] expd);
        set_req(op, addr, len, data, opq);
        @(negedge clk); chk({nm, "_rdy"}, 64'(mem_if.req_rdy), 64'd1);
        next_cycle();
        mem_if.req_val = 1'b0;
        @(negedge clk); chk({nm, "_early"}, 64'(mem_if.resp_val), 64'd0);
        next_cycle();
        @(negedge clk);
        chk({nm, "_val"}, 64'(mem_if.resp_val), 64'd1);
        chk({nm, "_msg"}, 64'(mem_if.resp_msg), 64'(exp_resp(op, opq, len, expd)));
        next_cycle();
    endtask

    // Streams n reads, holding resp_rdy low for the first 'hold' cycles; bounded to 80 cycles.
    task automatic stream(input int n, input logic [7:0] opq0, input logic [31:0] addr,
                          input int hold, output int acc_hold, output int last_acc,
                          output logic rdy_rel, output logic rdy_after, output logic stable);
        int        sent;
        mem_resp_t snap;
        sent = 0; acc_hold = -1; last_acc = -1;
        rdy_rel = 1'b0; rdy_after = 1'b0; stable = 1'b1; snap = '0;
        got.delete();
        for (int c = 0; c < 80 && got.size() < n; c++) begin
            mem_if.resp_rdy = (c >= hold);
            if (sent < n) set_req(MEM_MSG_READ, addr, 2'd0, 32'h0, opq0 + 8'(sent));
            else mem_if.req_val = 1'b0;
            @(negedge clk);
            if (mem_if.resp_val && mem_if.resp_rdy) got.push_back(mem_if.resp_msg);
            if (c == hold - 4) snap = mem_if.resp_msg;
            if (c > hold - 4 && c < hold && mem_if.resp_msg !== snap) stable = 1'b0;
            if (c == hold) rdy_rel = mem_if.req_rdy;
            if (c == hold + 1) rdy_after = mem_if.req_rdy;
            if (mem_if.req_val && mem_if.req_rdy) begin
                sent++;
                last_acc = c;
            end
            if (c == hold - 1) acc_hold = sent;
            next_cycle();
        end
        mem_if.req_val  = 1'b0;
        mem_if.resp_rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   acc_hold, last_acc, cnt_v;
        logic rdy_rel, rdy_after, stable;

        vecs[0]  = '{MEM_MSG_READ,  32'h0000_0010, 2'd0, 32'h0,         8'h3a, 32'hdead_beef};
        vecs[1]  = '{MEM_MSG_WRITE, 32'h0000_0023, 2'd1, 32'h0000_00ab, 8'h21, 32'h0};
        vecs[2]  = '{MEM_MSG_READ,  32'h0000_0020, 2'd0, 32'h0,         8'h22, 32'hab34_5678};
        vecs[3]  = '{MEM_MSG_READ,  32'h0000_0022, 2'd2, 32'h0,         8'h23, 32'h0000_ab34};
        vecs[4]  = '{MEM_MSG_READ,  32'h0000_0021, 2'd1, 32'h0,         8'h24, 32'h0000_0056};
        vecs[5]  = '{MEM_MSG_READ,  32'h0000_0023, 2'd3, 32'h0,         8'h25, 32'h0000_00ab};
        vecs[6]  = '{MEM_MSG_READ,  32'h0000_0022, 2'd0, 32'h0,         8'h26, 32'h0000_ab34};
        vecs[7]  = '{MEM_MSG_WRITE, 32'h0000_0031, 2'd2, 32'h1234_beef, 8'h27, 32'h0};
        vecs[8]  = '{MEM_MSG_READ,  32'h0000_0030, 2'd0, 32'h0,         8'h28, 32'h00be_ef00};
        vecs[9]  = '{MEM_MSG_WRITE, 32'h0000_0400, 2'd0, 32'hcafe_f00d, 8'h29, 32'h0};
        vecs[10] = '{MEM_MSG_READ,  32'h0000_0000, 2'd0, 32'h0,         8'h2a, 32'hcafe_f00d};
        vecs[11] = '{MEM_MSG_READ,  32'hffff_fc10, 2'd0, 32'h0,         8'h2b, 32'hdead_beef};
        vecs[12] = '{MEM_MSG_READ,  32'h0000_0011, 2'd3, 32'h0,         8'h2c, 32'h00de_adbe};

        rst = 1'b1; init_en = 1'b0; init_addr = '0; init_data = '0;
        mem_if.req_val = 1'b0; mem_if.req_msg = '0; mem_if.resp_rdy = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_req_rdy",  64'(mem_if.req_rdy),  64'd0);
        chk("reset_resp_val", 64'(mem_if.resp_val), 64'd0);
        chk("reset_resp_msg", 64'(mem_if.resp_msg), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk); chk("post_reset_rdy", 64'(mem_if.req_rdy), 64'd1);
        next_cycle();

        do_init(32'h0000_0010, 32'hdead_beef);
        do_init(32'h0000_0030, 32'h0000_0000);

        // Back-to-back write then read of the same word.
        set_req(MEM_MSG_WRITE, 32'h20, 2'd0, 32'h1234_5678, 8'h11);
        next_cycle();
        set_req(MEM_MSG_READ, 32'h20, 2'd0, 32'h0, 8'h12);
        @(negedge clk);
        chk("b2b_rdy", 64'(mem_if.req_rdy), 64'd1);
        chk("b2b_early", 64'(mem_if.resp_val), 64'd0);
        next_cycle();
        mem_if.req_val = 1'b0;
        @(negedge clk);
        chk("b2b_wr_msg", 64'(mem_if.resp_msg), 64'(exp_resp(MEM_MSG_WRITE, 8'h11, 2'd0, 32'h0)));
        next_cycle();
        @(negedge clk);
        chk("b2b_rd_msg", 64'(mem_if.resp_msg), 64'(exp_resp(MEM_MSG_READ, 8'h12, 2'd0, 32'h1234_5678)));
        next_cycle();

        // Init blocks the request for one cycle, the read then sees the init data.
        init_en = 1'b1; init_addr = 32'h40; init_data = 32'h1122_3344;
        set_req(MEM_MSG_READ, 32'h40, 2'd0, 32'h0, 8'h13);
        @(negedge clk); chk("init_blocks_rdy", 64'(mem_if.req_rdy), 64'd0);
        next_cycle();
        init_en = 1'b0;
        single("rd_after_init", MEM_MSG_READ, 32'h40, 2'd0, 32'h0, 8'h13, 32'h1122_3344);

        for (int i = 0; i < 13; i++) begin
            single($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].len,
                   vecs[i].data, vecs[i].opq, vecs[i].expd);
        end

        // Backpressure: 6 reads against a 4-deep credit window.
        stream(6, 8'h80, 32'h0, 10, acc_hold, last_acc, rdy_rel, rdy_after, stable);
        chk("bp_accepted_at_hold", 64'(acc_hold), 64'd4);
        chk("bp_rdy_on_full_deq", 64'(rdy_rel), 64'd0);
        chk("bp_rdy_next", 64'(rdy_after), 64'd1);
        chk("bp_msg_stable", 64'(stable), 64'd1);
        chk("bp_count", 64'(got.size()), 64'd6);
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("bp_resp%0d", i), 64'(got[i]),
                64'(exp_resp(MEM_MSG_READ, 8'(8'h80 + i), 2'd0, 32'hcafe_f00d)));
        end

        // Sustained traffic wraps the queue pointers several times.
        stream(16, 8'h40, 32'h10, 0, acc_hold, last_acc, rdy_rel, rdy_after, stable);
        chk("sus_count", 64'(got.size()), 64'd16);
        chk("sus_last_accept_cycle", 64'(last_acc), 64'd15);
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("sus_resp%0d", i), 64'(got[i]),
                64'(exp_resp(MEM_MSG_READ, 8'(8'h40 + i), 2'd0, 32'hdead_beef)));
        end

        // Reset with three requests in flight.
        set_req(MEM_MSG_WRITE, 32'h60, 2'd0, 32'h5a5a_5a5a, 8'h70);
        next_cycle();
        set_req(MEM_MSG_READ, 32'h0, 2'd0, 32'h0, 8'h71);
        next_cycle();
        set_req(MEM_MSG_READ, 32'h10, 2'd0, 32'h0, 8'h72);
        next_cycle();
        mem_if.req_val = 1'b0;
        rst = 1'b1;
        @(negedge clk); chk("midrst_rdy", 64'(mem_if.req_rdy), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rdy_after", 64'(mem_if.req_rdy), 64'd1);
        chk("midrst_msg_cleared", 64'(mem_if.resp_msg), 64'd0);
        cnt_v = 0;
        for (int c = 0; c < 6; c++) begin
            if (mem_if.resp_val) cnt_v++;
            next_cycle();
            @(negedge clk);
        end
        chk("midrst_no_resp", 64'(cnt_v), 64'd0);
        next_cycle();
        single("midrst_persist_wr", MEM_MSG_READ, 32'h60, 2'd0, 32'h0, 8'h73, 32'h5a5a_5a5a);
        single("midrst_persist_a0", MEM_MSG_READ, 32'h0,  2'd0, 32'h0, 8'h74, 32'hcafe_f00d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
